// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter sharing the single NPC memory port between IFU and LSU.
// One outstanding access at a time; a watchdog aborts accesses that never complete.
module ysyx_24100005_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              bus_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]        state;
    logic              last_lsu;
    logic              owner_lsu;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              ifu_rsp_q;
    logic              lsu_rsp_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q;

    logic              grant_ifu;
    logic              grant_lsu;
    logic              in_idle;
    logic              timer_hit;

    // With both requesting, the one that did not win last time gets the port.
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || last_lsu);
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
    assign in_idle   = (state == S_IDLE);
    assign timer_hit = (timer == T_LAST);

    assign ifu_req_ready = in_idle && grant_ifu;
    assign lsu_req_ready = in_idle && grant_lsu;

    assign mem_req_valid = (state == S_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = ifu_rsp_q;
    assign lsu_rsp_valid = lsu_rsp_q;
    assign ifu_rsp_data  = ifu_rsp_q ? rsp_data_q : '0;
    assign lsu_rsp_data  = lsu_rsp_q ? rsp_data_q : '0;
    assign bus_err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_lsu   <= 1'b1;
            owner_lsu  <= 1'b0;
            timer      <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            ifu_rsp_q  <= 1'b0;
            lsu_rsp_q  <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ifu_rsp_q <= 1'b0;
            lsu_rsp_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner_lsu <= grant_lsu;
                        last_lsu  <= grant_lsu;
                        addr_q    <= grant_lsu ? lsu_addr : ifu_addr;
                        wen_q     <= grant_lsu && lsu_wen;
                        wdata_q   <= grant_lsu ? lsu_wdata : '0;
                        wmask_q   <= grant_lsu ? lsu_wmask : '0;
                        timer     <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        timer <= '0;
                        state <= S_WAIT;
                    end else if (timer_hit) begin
                        ifu_rsp_q  <= !owner_lsu;
                        lsu_rsp_q  <= owner_lsu;
                        rsp_data_q <= '0;
                        err_q      <= 1'b1;
                        timer      <= '0;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        ifu_rsp_q  <= !owner_lsu;
                        lsu_rsp_q  <= owner_lsu;
                        // A store only needs the ack; its data field reads as zero.
                        rsp_data_q <= (owner_lsu && wen_q) ? '0 : mem_rsp_data;
                        timer      <= '0;
                        state      <= S_IDLE;
                    end else if (timer_hit) begin
                        ifu_rsp_q  <= !owner_lsu;
                        lsu_rsp_q  <= owner_lsu;
                        rsp_data_q <= '0;
                        err_q      <= 1'b1;
                        timer      <= '0;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Randomized bench for the IFU/LSU memory arbiter against a transaction-level model
// that predicts grant order, memory-side fields, response cycle, data and abort.
module tb_ysyx_24100005_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [7:0]  mem_wmask;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit          lsu_last = 1'b1;
    bit          pend     = 1'b0;
    bit          p_lsu, p_err;
    logic [31:0] p_data;

    ysyx_24100005_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response outputs in an IDLE cycle: either the predicted pulse or nothing.
    task automatic check_pending();
        check("ifu_rsp_valid", ifu_rsp_valid, pend && !p_lsu);
        check("lsu_rsp_valid", lsu_rsp_valid, pend && p_lsu);
        check("bus_err", bus_err, pend && p_err);
        if (pend) check("rsp_data", p_lsu ? lsu_rsp_data : ifu_rsp_data, p_data);
        pend = 1'b0;
    endtask

    // dq: cycles mem_req_ready stays low; dr: cycles before mem_rsp_valid once in WAIT.
    task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia,
                           input logic [31:0] la, input bit wen, input logic [31:0] wd,
                           input logic [7:0] wm, input int dq, input int dr,
                           input logic [31:0] rdata);
        bit          win_lsu, ab_i, ab_w;
        int          ic, w0, wc, p;
        logic [31:0] e_addr, e_wd;
        logic [7:0]  e_wm;
        bit          e_wen;
        @(negedge clk);
        check_pending();
        ifu_req_valid = iv;  ifu_addr  = ia;
        lsu_req_valid = lv;  lsu_addr  = la;
        lsu_wen       = wen; lsu_wdata = wd; lsu_wmask = wm;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = $urandom;
        #1;
        win_lsu = lv && (!iv || !lsu_last);
        check("ifu_req_ready", ifu_req_ready, iv && !win_lsu);
        check("lsu_req_ready", lsu_req_ready, win_lsu);
        check("idle_mem_req_valid", mem_req_valid, 1'b0);
        lsu_last = win_lsu;
        e_addr = win_lsu ? la : ia;
        e_wen  = win_lsu && wen;
        e_wd   = win_lsu ? wd : 32'h0;
        e_wm   = win_lsu ? wm : 8'h0;
        ab_i = (dq >= TO);
        ab_w = (dr >= TO);
        ic   = ab_i ? TO : dq + 1;
        w0   = dq + 2;
        wc   = ab_w ? TO : dr + 1;
        p    = ab_i ? 1 + TO : w0 + wc;
        for (int c = 1; c < p; c++) begin
            @(negedge clk);
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            mem_req_ready = (c == dq + 1);
            mem_rsp_valid = (!ab_i && !ab_w && c == w0 + dr) ||
                            (c <= ic && $urandom_range(0, 3) == 0);
            mem_rsp_data  = (c == w0 + dr) ? rdata : $urandom;
            #1;
            check("mem_req_valid", mem_req_valid, c <= ic);
            if (c <= ic) begin
                check("mem_addr", mem_addr, e_addr);
                check("mem_wen", mem_wen, e_wen);
                check("mem_wdata", mem_wdata, e_wd);
                check("mem_wmask", mem_wmask, e_wm);
            end
            check("early_ifu_rsp", ifu_rsp_valid, 1'b0);
            check("early_lsu_rsp", lsu_rsp_valid, 1'b0);
            check("early_bus_err", bus_err, 1'b0);
        end
        pend   = 1'b1;
        p_lsu  = win_lsu;
        p_err  = ab_i || ab_w;
        p_data = (p_err || e_wen) ? 32'h0 : rdata;
    endtask

    // Reset asserted while the IFU fetch sits in WAIT; a stray response follows.
    task automatic reset_in_wait();
        @(negedge clk);
        check_pending();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        check("rw_ifu_ready", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("rw_issue", mem_req_valid, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("rw_wait", mem_req_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rw_rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rw_rst_mem_addr", mem_addr, 32'h0);
        check("rw_rst_ifu_rsp", ifu_rsp_valid, 1'b0);
        check("rw_rst_lsu_rsp", lsu_rsp_valid, 1'b0);
        check("rw_rst_bus_err", bus_err, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rw_stray_ifu_rsp", ifu_rsp_valid, 1'b0);
        check("rw_stray_bus_err", bus_err, 1'b0);
        check("rw_stray_mem_req", mem_req_valid, 1'b0);
        mem_rsp_valid = 1'b0;
        lsu_last = 1'b1;
        pend     = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wmask", mem_wmask, 8'h0);
        check("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        check("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        rst = 1'b1;

        // Simultaneous requests from reset: IFU first, then strict alternation.
        for (int k = 0; k < 4; k++)
            run_txn(1, 1, 32'h8000_0000 + 32'(4 * k), 32'h8000_0200 + 32'(4 * k), 1'b0,
                    32'h0, 8'h0, 0, k, 32'hA000_0000 + 32'(k));
        // Minimal-latency fetch.
        run_txn(1, 0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h0, 0, 0, 32'h0010_0093);
        // Store: fields forwarded, ack data reads zero.
        run_txn(0, 1, 32'h0, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 8'h0F, 0, 1, 32'hFFFF_FFFF);
        // Bridge back-pressure for 5 cycles.
        run_txn(0, 1, 32'h0, 32'h8000_0104, 1'b0, 32'h5555_5555, 8'hFF, 5, 0, 32'hCAFE_F00D);
        // Watchdog in WAIT, then in ISSUE.
        run_txn(1, 0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 8'h0, 0, TO, 32'h7777_7777);
        run_txn(0, 1, 32'h0, 32'h8000_0300, 1'b1, 32'h0BAD_0BAD, 8'h03, TO, 0, 32'h6666_6666);
        // Longest response that still beats the watchdog.
        run_txn(1, 0, 32'h8000_0014, 32'h0, 1'b0, 32'h0, 8'h0, 0, TO - 1, 32'h1357_9BDF);
        reset_in_wait();
        run_txn(1, 1, 32'h8000_0020, 32'h8000_0400, 1'b0, 32'h0, 8'h0, 0, 0, 32'h2468_ACE0);

        for (int i = 0; i < 40; i++) begin
            bit iv, lv;
            int dq, dr;
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            dq = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
            dr = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
            run_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    8'($urandom), dq, dr, $urandom);
        end

        @(negedge clk);
        check_pending();
        @(negedge clk);
        check_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
